// File: rtl/serial_sub8.sv
// Bit-serial subtractor: one full-subtractor cell and a registered borrow,
// LSB first, so a WIDTH-bit difference takes WIDTH clocks.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             d_bit, br_next;

  always_comb begin
    d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    br_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        // Visible results change only here, on the edge that enters DONE.
        if (cnt_q == LAST) begin
          diff_d   = res_d;
          borrow_d = br_next;
          ovf_d    = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Scoreboard bench for serial_sub8: stimulus pushes expected results computed
// with plain arithmetic; a monitor pops and compares on every done pulse.
module tb_serial_sub8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, borrow, ovf;
  logic [7:0] diff;

  serial_sub8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  d;
    logic        br;
    logic        ov;
    int unsigned acc;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         done_seen = 0;
  int         pushed = 0;
  logic [7:0] last_diff = 8'h00;
  logic [7:0] prev_diff = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   sd;
    e.d  = x - y;
    e.br = (x < y);
    sd   = int'($signed(x)) - int'($signed(y));
    e.ov = (sd > 127) || (sd < -128);
    e.acc = 0;
    return e;
  endfunction

  // All tasks are entered and left at 1 time unit after a rising edge.
  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    int unsigned n = 0;
    exp_t e;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", {31'd0, busy}, 32'd0);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = model(x, y);
    e.acc = cyc;
    sb.push_back(e);
    pushed++;
    prev_diff = last_diff;
    last_diff = e.d;
    a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    int          seen;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n && done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: got done=1 required no pending operation");
            end else begin
              e = sb.pop_front();
              chk("diff", {24'd0, diff}, {24'd0, e.d});
              chk("borrow", {31'd0, borrow}, {31'd0, e.br});
              chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
              chk("latency", cyc - e.acc, 32'd8);
            end
          end
        end
      end
    join_none

    // Reset state
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_outs", {22'd0, diff, borrow, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Equal operands, busy duration
    issue(8'h54, 8'h54);
    n = 1;
    while (busy === 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk("busy_cycles", n - 1, 32'd9);
    wait_idle();

    issue(8'h56, 8'h54); wait_idle();
    issue(8'h54, 8'h57); wait_idle();
    issue(8'h80, 8'h01); wait_idle();
    issue(8'h7F, 8'hFF); wait_idle();
    issue(8'hA7, 8'h00); wait_idle();
    issue(8'hFF, 8'hFF); wait_idle();
    issue(8'h80, 8'h01); wait_idle();

    // Start during RUN is ignored; previous result holds during RUN
    issue(8'h74, 8'h5C);
    @(posedge clk); #1;
    chk("diff_hold_run", {24'd0, diff}, {24'd0, prev_diff});
    a = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("diff_hold_run2", {24'd0, diff}, {24'd0, prev_diff});
    wait_idle();
    chk("single_done", done_seen, pushed);

    // Back-to-back: second start on the cycle after done
    issue(8'h11, 8'h22);
    issue(8'h54, 8'h7F);
    wait_idle();

    // Asynchronous reset mid-RUN aborts the operation
    issue(8'h12, 8'h34);
    repeat (4) begin @(posedge clk); #1; end
    seen = done_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_outs", {22'd0, diff, borrow, ovf}, 32'd0);
    sb.delete();
    pushed--;
    last_diff = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(8'h56, 8'h54);
    wait_idle();
    chk("abort_no_done", done_seen, seen + 1);

    // Randomized operations with gaps, back-to-back and ignored starts
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        a = 8'($urandom); b = 8'($urandom); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    chk("done_count", done_seen, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_sub8.md
SERIAL_SUB8 -- requirements
Module: serial_sub8

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; all requirements and checks are written for WIDTH=8.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; captured on the edge that accepts start.
REQ-007 busy  output  1  high while a subtraction is in progress (RUN or DONE state).
REQ-008 done  output  1  one-cycle pulse; result outputs valid while high.
REQ-009 diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 borrow  output  1  unsigned borrow-out; high when a<b (unsigned).
REQ-011 ovf  output  1  signed (two's complement) overflow of a-b.

Function
REQ-012 The block SHALL be a bit-serial subtractor processing one bit per clock, LSB first, using one full-subtractor cell and a registered borrow.
REQ-013 FSM states SHALL be IDLE, RUN and DONE, encoded in registers, with all transitions on rising clk.
REQ-014 IDLE: start=1 at an edge SHALL latch a and b into shift registers, clear the borrow register, clear the 3-bit bit counter, and enter RUN; start=0 SHALL leave the block in IDLE.
REQ-015 RUN: each edge SHALL compute d_i=a_i^b_i^br and br'=(~a_i&b_i)|(~(a_i^b_i)&br), shift d_i into the result register MSB-first (so bit 0 ends at diff[0]), and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges; the edge processing bit WIDTH-1 SHALL move the FSM to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-018 Latency: with start accepted at edge E0, done SHALL be high between edge E(WIDTH) and edge E(WIDTH+1), which is 8 clocks for WIDTH=8.
REQ-019 diff, borrow and ovf SHALL update only on the edge entering DONE, and SHALL hold until the next DONE entry; they SHALL NOT change during RUN.
REQ-020 borrow SHALL equal the final serial borrow; ovf SHALL be (a[MSB]!=b[MSB]) & (diff[MSB]!=a[MSB]) using the captured operands.
REQ-021 start asserted in RUN or DONE SHALL be ignored and not queued; a, b changes after capture SHALL NOT affect the result.
REQ-022 busy SHALL be 1 in RUN and DONE and 0 in IDLE, which allows start on the cycle after done.
REQ-023 a=b SHALL give diff=0, borrow=0, ovf=0; b=0 SHALL give diff=a, borrow=0.

Reset
REQ-024 rst_n low SHALL immediately, without a clock edge, force the FSM to IDLE and set busy=0, done=0, diff=0, borrow=0, ovf=0, and clear the counter, the operand registers and the borrow register.
REQ-025 rst_n asserted mid-RUN SHALL abort the operation with no done pulse; after release, the first start SHALL behave as from power-up.
REQ-026 The first edge after rst_n deasserts SHALL be able to accept start.

Verification
REQ-027 a=0x54, b=0x54, start one cycle -> done 8 clocks later with diff=0x00, borrow=0, ovf=0; busy high for 9 cycles.
REQ-028 Check a=0x56, b=0x54 -> diff=0x02, borrow=0. Check a=0x54, b=0x57 -> diff=0xFD, borrow=1, ovf=0.
REQ-029 Check a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow=0. Check a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
REQ-030 Start with a=0x74, b=0x5C, then pulse start with a=0x00 during RUN -> exactly one done, diff=0x18, no second done.
REQ-031 Back-to-back: raise start on the cycle after done with a=0x54, b=0x7F -> second done 8 clocks after acceptance with diff=0xD5, borrow=1.
REQ-032 Assert rst_n low at RUN bit 4 -> outputs are 0 immediately and no done appears; after release, a=0x56, b=0x54 -> diff=0x02.
